// File: rtl/cam_pkg.sv
// Shared CAM types and sizes used by the requester, the CAM and the bench.
// Op encoding matches the request channel's 2-bit op field.
package cam_pkg;

    localparam int DATA_W  = 32;
    localparam int IDX_W   = 5;
    localparam int ENTRIES = 32;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_SEARCH = 2'd2,
        OP_LEARN  = 2'd3
    } cam_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_LEARN_WR,
        S_RESP
    } cam_req_state_e;

endpackage

// File: rtl/cam_requester_if.sv
// Request/response valid-ready channel between the lookup client and the requester.
// The master is the client and the slave is the requester.
interface cam_requester_if;
    import cam_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic [IDX_W-1:0]  req_index_i;
    logic [DATA_W-1:0] req_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [1:0]        rsp_op_o;
    logic              rsp_hit_o;
    logic [IDX_W-1:0]  rsp_index_o;
    logic [DATA_W-1:0] rsp_data_o;

    modport master (
        output req_valid_i, req_op_i, req_index_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_index_o,
        input  rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_index_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_index_o,
        output rsp_data_o
    );

endinterface

// File: rtl/cam_requester.sv
// CAM initiator: one command at a time, drives CAM enables, returns the result.
// LEARN searches and, on a miss, inserts the key at a round-robin victim slot.
module cam_requester
    import cam_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    cam_requester_if.slave    bus,
    output logic              read_enable_o,
    output logic [IDX_W-1:0]  read_index_o,
    output logic              write_enable_o,
    output logic [IDX_W-1:0]  write_index_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              search_enable_o,
    output logic [DATA_W-1:0] search_data_o,
    input  logic              read_valid_i,
    input  logic [DATA_W-1:0] read_value_i,
    input  logic              search_valid_i,
    input  logic [IDX_W-1:0]  search_index_i
);

    cam_req_state_e    state, state_nxt;
    cam_op_e           op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic              hit_q;
    logic [IDX_W-1:0]  rsp_idx_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [IDX_W-1:0]  victim;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= OP_READ;
            idx_q      <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            rsp_idx_q  <= '0;
            rsp_data_q <= '0;
            victim     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        op_q   <= cam_op_e'(bus.req_op_i);
                        idx_q  <= bus.req_index_i;
                        data_q <= bus.req_data_i;
                    end
                end
                S_ISSUE: begin
                    if (op_q == OP_WRITE) begin
                        hit_q      <= 1'b0;
                        rsp_idx_q  <= idx_q;
                        rsp_data_q <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (op_q == OP_READ) begin
                        hit_q      <= read_valid_i;
                        rsp_idx_q  <= idx_q;
                        rsp_data_q <= read_value_i;
                    end else begin
                        hit_q      <= search_valid_i;
                        rsp_idx_q  <= search_valid_i ? search_index_i : '0;
                        rsp_data_q <= '0;
                    end
                end
                S_LEARN_WR: begin
                    hit_q     <= 1'b0;
                    rsp_idx_q <= victim;
                    victim    <= (victim == IDX_W'(ENTRIES - 1))
                                 ? '0 : victim + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.req_ready_o = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.rsp_op_o    = '0;
        bus.rsp_hit_o   = 1'b0;
        bus.rsp_index_o = '0;
        bus.rsp_data_o  = '0;
        read_enable_o   = 1'b0;
        read_index_o    = '0;
        write_enable_o  = 1'b0;
        write_index_o   = '0;
        write_data_o    = '0;
        search_enable_o = 1'b0;
        search_data_o   = '0;
        unique case (state)
            S_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                unique case (op_q)
                    OP_READ: begin
                        read_enable_o = 1'b1;
                        read_index_o  = idx_q;
                    end
                    OP_WRITE: begin
                        write_enable_o = 1'b1;
                        write_index_o  = idx_q;
                        write_data_o   = data_q;
                    end
                    default: begin
                        search_enable_o = 1'b1;
                        search_data_o   = data_q;
                    end
                endcase
                state_nxt = (op_q == OP_WRITE) ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (op_q == OP_LEARN && !search_valid_i) state_nxt = S_LEARN_WR;
                else                                     state_nxt = S_RESP;
            end
            S_LEARN_WR: begin
                write_enable_o = 1'b1;
                write_index_o  = victim;
                write_data_o   = data_q;
                state_nxt      = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_op_o    = op_q;
                bus.rsp_hit_o   = hit_q;
                bus.rsp_index_o = rsp_idx_q;
                bus.rsp_data_o  = rsp_data_q;
                if (bus.rsp_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cam_requester.sv
// Bench for cam_requester with a behavioural 32-entry CAM and a response scoreboard.
// Drives and samples on the falling edge; the CAM model reacts on the rising edge.
module tb_cam_requester;
    import cam_pkg::*;

    typedef struct {
        logic [1:0]        op;
        logic              hit;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        int                lat;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              read_enable_o, write_enable_o, search_enable_o;
    logic [IDX_W-1:0]  read_index_o, write_index_o;
    logic [DATA_W-1:0] write_data_o, search_data_o;
    logic              read_valid_i = 1'b0;
    logic [DATA_W-1:0] read_value_i = '0;
    logic              search_valid_i = 1'b0;
    logic [IDX_W-1:0]  search_index_i = '0;

    logic [DATA_W-1:0] mem [ENTRIES];
    logic              vld [ENTRIES];

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_ptr = 0;

    cam_requester_if bus ();

    cam_requester dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .bus             (bus),
        .read_enable_o   (read_enable_o),
        .read_index_o    (read_index_o),
        .write_enable_o  (write_enable_o),
        .write_index_o   (write_index_o),
        .write_data_o    (write_data_o),
        .search_enable_o (search_enable_o),
        .search_data_o   (search_data_o),
        .read_valid_i    (read_valid_i),
        .read_value_i    (read_value_i),
        .search_valid_i  (search_valid_i),
        .search_index_i  (search_index_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            mem[i] = '0;
            vld[i] = 1'b0;
        end
    end

    // Registered CAM: results appear for one cycle after the enable edge
    always @(posedge clk_i) begin
        read_valid_i   <= 1'b0;
        read_value_i   <= '0;
        search_valid_i <= 1'b0;
        search_index_i <= '0;
        if (read_enable_o) begin
            read_valid_i <= vld[read_index_o];
            read_value_i <= vld[read_index_o] ? mem[read_index_o] : '0;
        end
        if (write_enable_o) begin
            mem[write_index_o] <= write_data_o;
            vld[write_index_o] <= 1'b1;
        end
        if (search_enable_o) begin
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (vld[i] && mem[i] == search_data_o) begin
                    search_valid_i <= 1'b1;
                    search_index_i <= IDX_W'(i);
                end
            end
        end
    end

    function automatic logic [99:0] outs_all();
        return {read_enable_o, read_index_o, write_enable_o, write_index_o,
                write_data_o, search_enable_o, bus.rsp_valid_o, bus.rsp_op_o,
                bus.rsp_hit_o, bus.rsp_index_o, bus.rsp_data_o, search_data_o[0]};
    endfunction

    task automatic do_cmd(input cam_op_e op, input logic [IDX_W-1:0] idx,
                          input logic [DATA_W-1:0] data, input logic ehit,
                          input logic [IDX_W-1:0] eidx,
                          input logic [DATA_W-1:0] edata, input int elat,
                          input int ewr_cyc, input logic [IDX_W-1:0] ewr_idx,
                          input int stall);
        exp_t e, got_e;
        int   wr_cyc, lat;
        logic [IDX_W-1:0]  wr_idx;
        logic [DATA_W-1:0] wr_data;
        logic [40:0] snap;
        bit got;
        e.op = op; e.hit = ehit; e.idx = eidx; e.data = edata; e.lat = elat;
        sb.push_back(e);
        vectors++;
        if (bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_idle got %b want 1", bus.req_ready_o);
        end
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_index_i = idx;
        bus.req_data_i  = data;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        wr_cyc = -1; wr_idx = '0; wr_data = '0; got = 0; lat = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (k > 0) @(negedge clk_i);
            if (write_enable_o === 1'b1) begin
                wr_cyc = k; wr_idx = write_index_o; wr_data = write_data_o;
            end
            if (k == 0) begin
                vectors++;
                if (read_enable_o !== (op == OP_READ) ||
                    search_enable_o !== (op == OP_SEARCH || op == OP_LEARN) ||
                    (op == OP_READ && read_index_o !== idx) ||
                    (search_enable_o && search_data_o !== data)) begin
                    miscompares++;
                    $display("FAIL issue_enables op %0d got rd=%b si=%b want op-matched",
                             op, read_enable_o, search_enable_o);
                end
            end
            if (bus.rsp_valid_o === 1'b1) begin
                got = 1; lat = k;
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL rsp_timeout op %0d got no rsp_valid want latency %0d", op, elat);
            void'(sb.pop_front());
            return;
        end
        got_e = sb.pop_front();
        if (lat != got_e.lat || bus.rsp_op_o !== got_e.op ||
            bus.rsp_hit_o !== got_e.hit || bus.rsp_index_o !== got_e.idx ||
            bus.rsp_data_o !== got_e.data) begin
            miscompares++;
            $display("FAIL rsp op %0d got lat=%0d op=%0d hit=%b idx=%0d data=%h want lat=%0d op=%0d hit=%b idx=%0d data=%h",
                     op, lat, bus.rsp_op_o, bus.rsp_hit_o, bus.rsp_index_o,
                     bus.rsp_data_o, got_e.lat, got_e.op, got_e.hit,
                     got_e.idx, got_e.data);
        end
        vectors++;
        if (wr_cyc != ewr_cyc ||
            (wr_cyc >= 0 && (wr_idx !== ewr_idx || wr_data !== data))) begin
            miscompares++;
            $display("FAIL cam_write op %0d got cyc=%0d idx=%0d data=%h want cyc=%0d idx=%0d data=%h",
                     op, wr_cyc, wr_idx, wr_data, ewr_cyc, ewr_idx, data);
        end
        if (stall > 0) begin
            snap = {bus.rsp_valid_o, bus.rsp_op_o, bus.rsp_hit_o,
                    bus.rsp_index_o, bus.rsp_data_o};
            bus.req_valid_i = 1'b1;
            bus.req_op_i    = OP_WRITE;
            bus.req_index_i = 5'd9;
            bus.req_data_i  = 32'hFFFF_0000;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk_i);
                vectors++;
                if ({bus.rsp_valid_o, bus.rsp_op_o, bus.rsp_hit_o,
                     bus.rsp_index_o, bus.rsp_data_o} !== snap ||
                    bus.req_ready_o !== 1'b0 || read_enable_o !== 1'b0 ||
                    write_enable_o !== 1'b0 || search_enable_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold cycle %0d got rsp=%h rdy=%b en=%b%b%b want rsp=%h rdy=0 en=000",
                             s, {bus.rsp_valid_o, bus.rsp_op_o, bus.rsp_hit_o,
                             bus.rsp_index_o, bus.rsp_data_o}, bus.req_ready_o,
                             read_enable_o, write_enable_o, search_enable_o, snap);
                end
            end
            bus.req_valid_i = 1'b0;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b0;
        vectors++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_release got valid=%b ready=%b want valid=0 ready=1",
                     bus.rsp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (outs_all() !== '0 || bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs got %h rdy=%b want 0 rdy=1",
                     outs_all(), bus.req_ready_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_write_read_search();
        do_cmd(OP_WRITE, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd3, '0, 1, 0, 5'd3, 0);
        do_cmd(OP_READ, 5'd3, '0, 1'b1, 5'd3, 32'hDEAD_BEEF, 2, -1, '0, 0);
        do_cmd(OP_READ, 5'd4, '0, 1'b0, 5'd4, '0, 2, -1, '0, 0);
        do_cmd(OP_SEARCH, '0, 32'hDEAD_BEEF, 1'b1, 5'd3, '0, 2, -1, '0, 0);
        do_cmd(OP_SEARCH, '0, 32'h1234_5678, 1'b0, 5'd0, '0, 2, -1, '0, 0);
    endtask

    task automatic test_learn();
        logic [DATA_W-1:0] key;
        for (int i = 0; i < ENTRIES + 1; i++) begin
            key = 32'hA5A5_A5A5 + DATA_W'(i);
            do_cmd(OP_LEARN, '0, key, 1'b0, IDX_W'(exp_ptr), '0, 3, 2,
                   IDX_W'(exp_ptr), 0);
            exp_ptr = (exp_ptr + 1) % ENTRIES;
        end
        key = 32'hA5A5_A5A5 + 32'd5;
        do_cmd(OP_LEARN, '0, key, 1'b1, 5'd5, '0, 2, -1, '0, 0);
        do_cmd(OP_LEARN, '0, 32'h0BAD_F00D, 1'b0, IDX_W'(exp_ptr), '0, 3, 2,
               IDX_W'(exp_ptr), 0);
        exp_ptr = (exp_ptr + 1) % ENTRIES;
    endtask

    task automatic test_backpressure();
        do_cmd(OP_READ, 5'd5, '0, 1'b1, 5'd5, 32'hA5A5_A5AA, 2, -1, '0, 10);
        do_cmd(OP_SEARCH, '0, 32'h0BAD_F00D, 1'b1, 5'd1, '0, 2, -1, '0, 0);
    endtask

    task automatic test_reset_in_learn_wr();
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = OP_LEARN;
        bus.req_index_i = '0;
        bus.req_data_i  = 32'h7777_1111;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        vectors++;
        if (write_enable_o !== 1'b1 || write_index_o !== IDX_W'(exp_ptr)) begin
            miscompares++;
            $display("FAIL learn_wr_state got we=%b idx=%0d want we=1 idx=%0d",
                     write_enable_o, write_index_o, exp_ptr);
        end
        #2 rst_i = 1'b1;
        #1;
        sb.delete();
        exp_ptr = 0;
        vectors++;
        if (outs_all() !== '0 || bus.req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got %h rdy=%b want 0 rdy=1",
                     outs_all(), bus.req_ready_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            vectors++;
            if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_quiet got valid=%b rdy=%b want 0 1",
                         bus.rsp_valid_o, bus.req_ready_o);
            end
        end
        do_cmd(OP_LEARN, '0, 32'h3C3C_3C3C, 1'b0, 5'd0, '0, 3, 2, 5'd0, 0);
        exp_ptr = 1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = '0;
        bus.req_index_i = '0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b0;
        test_reset();
        test_write_read_search();
        test_learn();
        test_backpressure();
        test_reset_in_learn_wr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
